// File: rtl/cmp_sort_ctrl_if.sv
// Handshake bundle for the sort controller: serial word input, sorted word
// output, and status. The controller is the slave; the source/consumer side
// is the master.
interface cmp_sort_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] swap_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, done, swap_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, done, swap_cnt
    );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// Sequential bubble-sort controller. Words are loaded serially, sorted in
// place with one shared 4-bit comparator (one compare per clock, fixed
// N(N-1)/2 cycles), then streamed out over valid/ready.

// Plain unsigned 4-bit magnitude comparator.
module cmp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       x,
    output logic       y,
    output logic       z
);
    assign x = (a > b);
    assign y = (a == b);
    assign z = (a < b);
endmodule

module cmp_sort_ctrl #(
    parameter int N      = 4,
    parameter int ASCEND = 1,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cmp_sort_ctrl_if.slave       bus
);
    localparam int IW = (N > 2) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST   = IW'(N - 1);
    localparam logic [IW-1:0] LAST_P = IW'(N - 2);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t            state, state_nx;
    logic [N-1:0][3:0] mem;
    logic [IW-1:0]     ld_idx, out_idx, pass, j, j_nx;
    logic              out_valid, done;
    logic [3:0]        out_data;
    logic [CNT_W-1:0]  swap_cnt;
    logic              cx, cy, cz, sw;
    logic              in_acc, out_acc, pass_end, last_cmp;

    assign j_nx = j + 1'b1;

    cmp4 u_cmp (.a(mem[j]), .b(mem[j_nx]), .x(cx), .y(cy), .z(cz));

    // Equal words never swap, which keeps the sort stable.
    assign sw       = ~cy & ((ASCEND != 0) ? cx : cz);
    assign in_acc   = bus.in_valid & bus.in_ready;
    assign out_acc  = out_valid & bus.out_ready;
    assign pass_end = (j == (LAST_P - pass));
    assign last_cmp = pass_end && (pass == LAST_P);

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state == SORT);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.done      = done;
    assign bus.swap_cnt  = swap_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // Next-state logic: LOAD -> SORT -> OUT -> LOAD.
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_acc && ld_idx == LAST)   state_nx = SORT;
            SORT:    if (last_cmp)                   state_nx = OUT;
            OUT:     if (out_acc && out_idx == LAST) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Datapath: word store, compare/swap schedule, swap counter, output stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem       <= '0;
            ld_idx    <= '0;
            out_idx   <= '0;
            pass      <= '0;
            j         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            swap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_acc) begin
                        mem[ld_idx] <= bus.in_data;
                        if (ld_idx == '0) swap_cnt <= '0;
                        if (ld_idx == LAST) begin
                            ld_idx <= '0;
                            pass   <= '0;
                            j      <= '0;
                        end else begin
                            ld_idx <= ld_idx + 1'b1;
                        end
                    end
                end
                SORT: begin
                    if (sw) begin
                        mem[j]    <= mem[j_nx];
                        mem[j_nx] <= mem[j];
                        if (swap_cnt != '1) swap_cnt <= swap_cnt + 1'b1;
                    end
                    if (pass_end) begin
                        j    <= '0;
                        pass <= pass + 1'b1;
                    end else begin
                        j <= j_nx;
                    end
                    // The final compare is always at j=0, so the post-swap
                    // head word is mem[1] when this compare swaps.
                    if (last_cmp) begin
                        out_valid <= 1'b1;
                        out_data  <= sw ? mem[1] : mem[0];
                        done      <= 1'b1;
                        out_idx   <= '0;
                    end
                end
                OUT: begin
                    if (out_acc) begin
                        if (out_idx == LAST) begin
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                        end else begin
                            out_idx  <= out_idx + 1'b1;
                            out_data <= mem[out_idx + 1'b1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Bench for cmp_sort_ctrl: an ascending and a descending instance share the
// same stimulus; each batch is checked against hand-computed sort results.
module tb_cmp_sort_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    int nvec  = 0;
    int nfail = 0;

    cmp_sort_ctrl_if #(.CNT_W(8)) ifa ();
    cmp_sort_ctrl_if #(.CNT_W(8)) ifd ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.out_ready = out_ready;
    assign ifd.in_valid  = in_valid;
    assign ifd.in_data   = in_data;
    assign ifd.out_ready = out_ready;

    cmp_sort_ctrl #(.N(4), .ASCEND(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    cmp_sort_ctrl #(.N(4), .ASCEND(0), .CNT_W(8)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][3:0] d;   // load order, d[0] first
        logic [3:0][3:0] ea;  // expected ascending output
        logic [3:0][3:0] ed;  // expected descending output
        int              sa;  // expected ascending swaps
        int              sd;  // expected descending swaps
        int              stall; // output index to stall at, -1 none
    } vec_t;

    vec_t v[6];

    function automatic logic [15:0] w4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load four words, wait out the sort, then drain the outputs.
    task automatic run_batch(input vec_t t);
        int cyc, bcnt, dcnt;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("in_ready_load", int'(ifa.in_ready), 1);
            in_valid = 1'b1;
            in_data  = t.d[i];
            step();
        end
        // During a stall batch keep offering a word that must be ignored.
        if (t.stall >= 0) begin
            in_valid = 1'b1;
            in_data  = 4'd5;
        end else begin
            in_valid = 1'b0;
        end
        chk("in_ready_sort", int'(ifa.in_ready), 0);
        cyc = 0; bcnt = 0; dcnt = 0;
        while (!ifa.out_valid && cyc < 50) begin
            if (ifa.busy) bcnt++;
            if (ifa.done) dcnt++;
            step();
            cyc++;
        end
        chk("first_out_latency", cyc, 6);
        chk("busy_cycles", bcnt, 6);
        chk("busy_in_out", int'(ifa.busy), 0);
        chk("done_first_out", int'(ifa.done), 1);
        for (int i = 0; i < 4; i++) begin
            if (i == t.stall) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (ifa.done) dcnt++;
                    step();
                    chk("stall_valid", int'(ifa.out_valid), 1);
                    chk("stall_data", int'(ifa.out_data), int'(t.ea[i]));
                end
                out_ready = 1'b1;
            end
            chk("out_valid", int'(ifa.out_valid), 1);
            chk("out_data_asc", int'(ifa.out_data), int'(t.ea[i]));
            chk("out_data_desc", int'(ifd.out_data), int'(t.ed[i]));
            if (ifa.done) dcnt++;
            if (i == 3) in_valid = 1'b0;
            step();
        end
        chk("done_pulses", dcnt, 1);
        chk("out_valid_end", int'(ifa.out_valid), 0);
        chk("in_ready_end", int'(ifa.in_ready), 1);
        chk("swap_cnt_asc", int'(ifa.swap_cnt), t.sa);
        chk("swap_cnt_desc", int'(ifd.swap_cnt), t.sd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0] = '{d: w4(3,8,7,1),     ea: w4(1,3,7,8),     ed: w4(8,7,3,1),     sa: 4, sd: 2, stall: -1};
        v[1] = '{d: w4(9,9,9,9),     ea: w4(9,9,9,9),     ed: w4(9,9,9,9),     sa: 0, sd: 0, stall: -1};
        v[2] = '{d: w4(15,11,7,1),   ea: w4(1,7,11,15),   ed: w4(15,11,7,1),   sa: 6, sd: 0, stall: -1};
        v[3] = '{d: w4(3,8,7,1),     ea: w4(1,3,7,8),     ed: w4(8,7,3,1),     sa: 4, sd: 2, stall: 2};
        v[4] = '{d: w4(0,15,0,15),   ea: w4(0,0,15,15),   ed: w4(15,15,0,0),   sa: 1, sd: 3, stall: -1};
        v[5] = '{d: w4(2,1,0,3),     ea: w4(0,1,2,3),     ed: w4(3,2,1,0),     sa: 3, sd: 3, stall: -1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", int'(ifa.in_ready), 1);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_out_valid", int'(ifa.out_valid), 0);
        chk("rst_out_data", int'(ifa.out_data), 0);
        chk("rst_done", int'(ifa.done), 0);
        chk("rst_swap_cnt", int'(ifa.swap_cnt), 0);
        rst = 1'b0;
        step();

        // Back-to-back batches: each load starts in the cycle after the last output.
        for (int n = 0; n < 5; n++) run_batch(v[n]);

        // Abort mid-sort with an asynchronous reset.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[0].d[i];
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("pre_abort_busy", int'(ifa.busy), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(ifa.busy), 0);
        chk("abort_in_ready", int'(ifa.in_ready), 1);
        chk("abort_out_valid", int'(ifa.out_valid), 0);
        chk("abort_done", int'(ifa.done), 0);
        chk("abort_swap_cnt", int'(ifa.swap_cnt), 0);
        chk("abort_swap_cnt_d", int'(ifd.swap_cnt), 0);
        #2;
        rst = 1'b0;
        step();
        run_batch(v[5]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
